// File: rtl/toy_bus_ack_pkg.sv
// Shared ToyBusAck definitions used by the ack-path decoder and arbiter nodes.
package toy_bus_ack_pkg;

  localparam int ACK_OP_W   = 1;
  localparam int ACK_DATA_W = 256;
  localparam int ACK_SB_W   = 32;
  localparam int ACK_ID_W   = 4;

  // One ack packet as carried through node buffers (opcode is the MSB end).
  typedef struct packed {
    logic [ACK_OP_W-1:0]   opcode;
    logic [ACK_DATA_W-1:0] data;
    logic [ACK_SB_W-1:0]   sideband;
    logic [ACK_ID_W-1:0]   src_id;
    logic [ACK_ID_W-1:0]   tgt_id;
  } ack_t;

  // Flattened payload width for a given set of field widths.
  function automatic int ack_w(input int dw, input int sw, input int iw);
    return ACK_OP_W + dw + sw + 2 * iw;
  endfunction

endpackage

// File: rtl/toy_bus_ack_buf2.sv
// Two-entry registered valid/ready FIFO carrying a flattened ack payload.
// The head is driven straight from storage, so nothing downstream reaches
// the push side combinationally.
module toy_bus_ack_buf2
  import toy_bus_ack_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  output logic         full_o,
  input  logic         pop_i,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         push_ok;
  logic         pop_ok;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Next-state for pointers and occupancy; 1-bit pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = ~wr_ptr_q;
    if (pop_ok)  rd_ptr_d = ~rd_ptr_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      // Entry storage: cleared on reset so the head reads zero when idle.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          mem_q[gi] <= '0;
        end else if (push_ok && (wr_ptr_q == 1'(gi))) begin
          mem_q[gi] <= push_data_i;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/toy_bus_arb_node_ack_rr.sv
// Round-robin merge of two ack streams into one buffered output channel.
// Holds only the grant decision and the round-robin pointer; buffering is
// delegated to toy_bus_ack_buf2.
module toy_bus_arb_node_ack_rr
  import toy_bus_ack_pkg::*;
#(
  parameter int DATA_W = ACK_DATA_W,
  parameter int SB_W   = ACK_SB_W,
  parameter int ID_W   = ACK_ID_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in0_vld,
  output logic              in0_rdy,
  input  logic              in0_opcode,
  input  logic [DATA_W-1:0] in0_data,
  input  logic [SB_W-1:0]   in0_sideband,
  input  logic [ID_W-1:0]   in0_src_id,
  input  logic [ID_W-1:0]   in0_tgt_id,
  input  logic              in1_vld,
  output logic              in1_rdy,
  input  logic              in1_opcode,
  input  logic [DATA_W-1:0] in1_data,
  input  logic [SB_W-1:0]   in1_sideband,
  input  logic [ID_W-1:0]   in1_src_id,
  input  logic [ID_W-1:0]   in1_tgt_id,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic              out_opcode,
  output logic [DATA_W-1:0] out_data,
  output logic [SB_W-1:0]   out_sideband,
  output logic [ID_W-1:0]   out_src_id,
  output logic [ID_W-1:0]   out_tgt_id
);

  localparam int PAY_W = ack_w(DATA_W, SB_W, ID_W);

  logic             rr_q, rr_d;
  logic             gnt_vld;
  logic             gnt_sel;
  logic             full;
  logic             empty;
  logic             push;
  logic [PAY_W-1:0] in0_pay, in1_pay, push_pay, head;

  assign in0_pay = {in0_opcode, in0_data, in0_sideband, in0_src_id, in0_tgt_id};
  assign in1_pay = {in1_opcode, in1_data, in1_sideband, in1_src_id, in1_tgt_id};

  // Grant: a lone valid input wins outright; on contention rr_q decides.
  always_comb begin
    gnt_vld = in0_vld || in1_vld;
    gnt_sel = 1'b0;
    if (in0_vld && in1_vld) gnt_sel = rr_q;
    else if (in1_vld)       gnt_sel = 1'b1;
  end

  // Ready is withheld during reset so nothing is accepted while held low.
  assign in0_rdy  = rst_n && gnt_vld && !gnt_sel && !full;
  assign in1_rdy  = rst_n && gnt_vld &&  gnt_sel && !full;
  assign push     = (in0_vld && in0_rdy) || (in1_vld && in1_rdy);
  assign push_pay = gnt_sel ? in1_pay : in0_pay;

  // After a push from input X the other input is favoured next time.
  always_comb begin
    rr_d = rr_q;
    if (push) rr_d = ~gnt_sel;
  end

  // Round-robin pointer register; reset favours input 0.
  always_ff @(posedge clk) begin
    if (!rst_n) rr_q <= 1'b0;
    else        rr_q <= rr_d;
  end

  toy_bus_ack_buf2 #(
    .W(PAY_W)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .push_data_i(push_pay),
    .full_o     (full),
    .pop_i      (out_rdy),
    .empty_o    (empty),
    .head_o     (head)
  );

  assign out_vld = !empty;
  assign {out_opcode, out_data, out_sideband, out_src_id, out_tgt_id} = head;

endmodule

// File: tb/tb_toy_bus_arb_node_ack_rr.sv
// Self-checking bench for toy_bus_arb_node_ack_rr: directed scenarios plus a
// randomized phase, checked against a queue-based reference model.
module tb_toy_bus_arb_node_ack_rr;
  import toy_bus_ack_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, in0_vld, in1_vld, out_rdy;
  logic in0_rdy, in1_rdy, out_vld;
  logic out_opcode;
  logic [ACK_DATA_W-1:0] out_data;
  logic [ACK_SB_W-1:0]   out_sideband;
  logic [ACK_ID_W-1:0]   out_src_id, out_tgt_id;
  ack_t p0, p1;

  toy_bus_arb_node_ack_rr dut (
    .clk(clk), .rst_n(rst_n),
    .in0_vld(in0_vld), .in0_rdy(in0_rdy), .in0_opcode(p0.opcode), .in0_data(p0.data),
    .in0_sideband(p0.sideband), .in0_src_id(p0.src_id), .in0_tgt_id(p0.tgt_id),
    .in1_vld(in1_vld), .in1_rdy(in1_rdy), .in1_opcode(p1.opcode), .in1_data(p1.data),
    .in1_sideband(p1.sideband), .in1_src_id(p1.src_id), .in1_tgt_id(p1.tgt_id),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_opcode(out_opcode), .out_data(out_data),
    .out_sideband(out_sideband), .out_src_id(out_src_id), .out_tgt_id(out_tgt_id)
  );

  // Reference model: packets in flight, and which input wins a tie.
  ack_t model_q[$];
  int   favoured = 0;
  bit   acc0, acc1;
  int   n_acc;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ack_t rand_pkt();
    ack_t p;
    p.opcode = 1'($urandom);
    for (int k = 0; k < 8; k++) p.data[k*32 +: 32] = $urandom;
    p.sideband = $urandom;
    p.src_id   = 4'($urandom);
    p.tgt_id   = 4'($urandom);
    return p;
  endfunction

  // One clock: check outputs at the falling edge, then advance the model.
  task automatic cycle();
    int   winner;
    bit   e0, e1, pop;
    ack_t pushed;
    @(negedge clk);
    winner = -1;
    if (in0_vld && in1_vld) winner = favoured;
    else if (in0_vld)       winner = 0;
    else if (in1_vld)       winner = 1;
    e0 = rst_n && (winner == 0) && (model_q.size() < 2);
    e1 = rst_n && (winner == 1) && (model_q.size() < 2);
    chk("in0_rdy", in0_rdy, e0);
    chk("in1_rdy", in1_rdy, e1);
    chk("out_vld", out_vld, model_q.size() != 0);
    if (model_q.size() != 0) begin
      chk("out_opcode",   out_opcode,   model_q[0].opcode);
      chk("out_data",     out_data,     model_q[0].data);
      chk("out_sideband", out_sideband, model_q[0].sideband);
      chk("out_src_id",   out_src_id,   model_q[0].src_id);
      chk("out_tgt_id",   out_tgt_id,   model_q[0].tgt_id);
    end
    pop    = (model_q.size() != 0) && out_rdy;
    pushed = (winner == 1) ? p1 : p0;
    @(posedge clk);
    #1;
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (!rst_n) begin
      model_q.delete();
      favoured = 0;
    end else begin
      if (pop) void'(model_q.pop_front());
      if (e0 || e1) begin
        model_q.push_back(pushed);
        favoured = 1 - winner;
        acc0 = e0;
        acc1 = e1;
      end
    end
    n_acc += int'(acc0) + int'(acc1);
    $display("t=%0t rst_n=%0b v0=%0b v1=%0b acc0=%0b acc1=%0b out_rdy=%0b depth=%0d",
             $time, rst_n, in0_vld, in1_vld, acc0, acc1, out_rdy, model_q.size());
  endtask

  // Replace any accepted payload with a fresh one.
  task automatic refresh();
    if (acc0) p0 = rand_pkt();
    if (acc1) p1 = rand_pkt();
  endtask

  initial begin
    rst_n = 1'b0; in0_vld = 1'b0; in1_vld = 1'b0; out_rdy = 1'b1;
    p0 = rand_pkt(); p1 = rand_pkt();

    // Reset held with in0 valid: nothing accepted, outputs idle and zero.
    p0.data   = {8{32'hA5A5A5A5}};
    p0.src_id = 4'd2;
    in0_vld   = 1'b1;
    repeat (3) cycle();
    chk("rst_out_data", out_data, '0);
    chk("rst_out_src",  out_src_id, '0);
    rst_n = 1'b1;
    cycle();
    chk("rst_release_accept", acc0, 1'b1);
    in0_vld = 1'b0;
    cycle();   // packet visible one cycle after acceptance
    cycle();

    // Contention at full rate: one accept per cycle, alternating.
    in0_vld = 1'b1; in1_vld = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("contention_tp", int'(acc0) + int'(acc1), 1);
      refresh();
    end
    in0_vld = 1'b0; in1_vld = 1'b0;
    repeat (3) cycle();

    // Backpressure: exactly two accepted, then outputs hold while stalled.
    out_rdy = 1'b0; in0_vld = 1'b1; in1_vld = 1'b1; n_acc = 0;
    for (int i = 0; i < 12; i++) begin cycle(); refresh(); end
    chk("bp_accepted", n_acc, 2);
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin cycle(); refresh(); end
    in0_vld = 1'b0; in1_vld = 1'b0;
    repeat (3) cycle();

    // Single source on input 1, then a tie must go to input 0.
    in1_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("single_src_acc", acc1, 1'b1);
      refresh();
    end
    in0_vld = 1'b1;
    cycle();
    chk("after_single_in0_wins", acc0, 1'b1);
    refresh();
    in0_vld = 1'b0; in1_vld = 1'b0;
    repeat (3) cycle();

    // Push and pop together at depth one.
    out_rdy = 1'b0; in0_vld = 1'b1; p0.tgt_id = 4'd0;
    cycle();
    refresh();
    in0_vld = 1'b0;
    cycle();
    out_rdy = 1'b1; in0_vld = 1'b1; p0.tgt_id = 4'd1;
    cycle();
    chk("pushpop_acc", acc0, 1'b1);
    chk("pushpop_depth", model_q.size(), 1);
    refresh();
    in0_vld = 1'b0;
    repeat (2) cycle();

    // Reset mid-stream with two packets buffered.
    out_rdy = 1'b0; in0_vld = 1'b1; in1_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin cycle(); refresh(); end
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    out_rdy = 1'b1;
    cycle();
    chk("midrst_in0_first", acc0, 1'b1);
    refresh();
    in0_vld = 1'b0; in1_vld = 1'b0;
    repeat (3) cycle();

    // Randomized traffic; a valid that was not accepted keeps its payload.
    for (int i = 0; i < 400; i++) begin
      if (!in0_vld || acc0) in0_vld = ($urandom_range(0, 3) != 0);
      if (!in1_vld || acc1) in1_vld = ($urandom_range(0, 3) != 0);
      out_rdy = ($urandom_range(0, 2) != 0);
      cycle();
      refresh();
    end
    in0_vld = 1'b0; in1_vld = 1'b0; out_rdy = 1'b1;
    repeat (4) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
